// File: rtl/stream_tx_arbiter.sv
// Round-robin arbiter sharing one byte-stream transmit path between N
// frame sources. It enforces an inter-frame gap, a grant-to-data timeout
// and a maximum forwarded frame length.
module stream_tx_arbiter #(
    parameter int unsigned N             = 4,
    parameter int unsigned IFG           = 12,
    parameter int unsigned GRANT_TIMEOUT = 64,
    parameter int unsigned MAX_LEN       = 1518
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] din,
    input  logic [N-1:0]   vin,
    output logic [N-1:0]   gnt,
    output logic [7:0]     dout,
    output logic           vout,
    output logic           busy,
    output logic           to_err,
    output logic           len_err
);

    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BW = $clog2(MAX_LEN + 1);
    localparam int unsigned TW = $clog2(GRANT_TIMEOUT + 1);
    localparam int unsigned GW = $clog2(IFG + 1);

    localparam logic [N-1:0] GNT_LSB = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_ACTIVE = 3'd2,
        S_DRAIN  = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_ptr;
    logic [SW-1:0]   r_sel;
    logic [N-1:0]    r_gnt;
    logic [7:0]      r_dout;
    logic            r_vout;
    logic            r_busy;
    logic            r_to_err;
    logic            r_len_err;
    logic [BW-1:0]   r_byte_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic [GW-1:0]   r_gap_cnt;

    logic [7:0]      w_din_arr [N];
    logic [7:0]      w_din_sel;
    logic            w_vin_sel;
    logic            w_req_sel;
    logic            w_any_req;
    logic [SW-1:0]   w_pick;
    logic [SW-1:0]   w_ptr_next;

    // Split the flat byte bus into one lane per source
    for (genvar g = 0; g < int'(N); g++) begin : g_lane
        assign w_din_arr[g] = din[8*g +: 8];
    end

    // Only the selected source's lane is ever looked at
    assign w_din_sel = w_din_arr[r_sel];
    assign w_vin_sel = vin[r_sel];
    assign w_req_sel = req[r_sel];

    // Round-robin pick: first requester at or after the pointer, wrapping;
    // scanning from the farthest offset down lets the nearest one win
    always_comb begin
        int unsigned k;
        w_any_req = 1'b0;
        w_pick    = r_ptr;
        k         = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (32'(r_ptr) + (N - 1 - i)) % N;
            if (req[SW'(k)]) begin
                w_any_req = 1'b1;
                w_pick    = SW'(k);
            end
        end
    end

    // Pointer moves to the source after the one just selected
    assign w_ptr_next = (w_pick == SW'(N - 1)) ? '0 : w_pick + SW'(1);

    // Arbitration FSM; every output is registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_sel      <= '0;
            r_gnt      <= '0;
            r_dout     <= '0;
            r_vout     <= 1'b0;
            r_busy     <= 1'b0;
            r_to_err   <= 1'b0;
            r_len_err  <= 1'b0;
            r_byte_cnt <= '0;
            r_to_cnt   <= '0;
            r_gap_cnt  <= '0;
        end else begin
            // Pulses and the data path default to idle every cycle
            r_to_err  <= 1'b0;
            r_len_err <= 1'b0;
            r_vout    <= 1'b0;
            r_dout    <= '0;

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_sel      <= w_pick;
                        r_ptr      <= w_ptr_next;
                        r_gnt      <= GNT_LSB << w_pick;
                        r_to_cnt   <= '0;
                        r_byte_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_GRANT;
                    end
                end

                S_GRANT: begin
                    if (w_vin_sel) begin
                        r_vout     <= 1'b1;
                        r_dout     <= w_din_sel;
                        r_byte_cnt <= BW'(1);
                        r_state    <= S_ACTIVE;
                    end else if (!w_req_sel) begin
                        // Source withdrew before sending: no gap needed
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_to_cnt == TW'(GRANT_TIMEOUT - 1)) begin
                        r_to_cnt  <= TW'(GRANT_TIMEOUT);
                        r_gnt     <= '0;
                        r_to_err  <= 1'b1;
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
                end

                S_ACTIVE: begin
                    if (w_vin_sel) begin
                        if (r_byte_cnt == BW'(MAX_LEN)) begin
                            // Over-length byte is dropped; keep grant until vin falls
                            r_len_err <= 1'b1;
                            r_state   <= S_DRAIN;
                        end else begin
                            r_vout     <= 1'b1;
                            r_dout     <= w_din_sel;
                            r_byte_cnt <= r_byte_cnt + BW'(1);
                        end
                    end else begin
                        r_gnt     <= '0;
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end
                end

                S_DRAIN: begin
                    if (!w_vin_sel) begin
                        r_gnt     <= '0;
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end
                end

                S_GAP: begin
                    // First GAP cycle is the first idle cycle on vout
                    if (r_gap_cnt == GW'(IFG - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end

                default: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign dout    = r_dout;
    assign vout    = r_vout;
    assign busy    = r_busy;
    assign to_err  = r_to_err;
    assign len_err = r_len_err;

endmodule

// File: tb/tb_stream_tx_arbiter.sv
// Directed bench for stream_tx_arbiter: forwarded bytes are scoreboarded,
// grant order, gap spacing and error pulses are checked at fixed points.
module tb_stream_tx_arbiter;

    localparam int IFG = 12;
    localparam int GT  = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        rst;
    logic [3:0]  req_a, vin_a, gnt_a, vin_a_dut;
    logic [31:0] din_a;
    logic [7:0]  dout_a;
    logic        vout_a, busy_a, to_err_a, len_err_a;
    logic        noise_en, noise_v = 1'b0;

    // Instance B: MAX_LEN = 16 for truncation
    logic        rst_b;
    logic [3:0]  req_b, vin_b, gnt_b;
    logic [31:0] din_b;
    logic [7:0]  dout_b;
    logic        vout_b, busy_b, to_err_b, len_err_b;

    assign vin_a_dut = vin_a | {noise_v, 3'b000};

    stream_tx_arbiter u_dut_a (
        .clk(clk), .rst(rst), .req(req_a), .din(din_a), .vin(vin_a_dut),
        .gnt(gnt_a), .dout(dout_a), .vout(vout_a), .busy(busy_a),
        .to_err(to_err_a), .len_err(len_err_a)
    );

    stream_tx_arbiter #(.MAX_LEN(16)) u_dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .din(din_b), .vin(vin_b),
        .gnt(gnt_b), .dout(dout_b), .vout(vout_b), .busy(busy_b),
        .to_err(to_err_b), .len_err(len_err_b)
    );

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int errors = 0;
    int checks = 0;
    int n_to_err_a = 0, n_len_err_a = 0, n_to_err_b = 0, n_len_err_b = 0;
    int n_vout_b = 0;
    int low_run = 0;
    bit seen_frame = 1'b0;
    bit prev_vout = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Toggles vin[3] of instance A while enabled
    always @(negedge clk) noise_v <= noise_en ? ~noise_v : 1'b0;

    // Output monitor: scoreboard pops, one-hot grant, gap spacing, pulse counts
    always @(negedge clk) begin
        check("gnt_onehot_a", 32'($onehot0(gnt_a)), 1);
        if (to_err_a)  n_to_err_a++;
        if (len_err_a) n_len_err_a++;
        if (to_err_b)  n_to_err_b++;
        if (len_err_b) n_len_err_b++;
        if (vout_a) begin
            if (q_a.size() == 0) check("a_unexpected_byte", 32'(dout_a), 32'hFFFF_FFFF);
            else check("a_byte", 32'(dout_a), 32'(q_a.pop_front()));
        end
        if (vout_b) begin
            n_vout_b++;
            if (q_b.size() == 0) check("b_unexpected_byte", 32'(dout_b), 32'hFFFF_FFFF);
            else check("b_byte", 32'(dout_b), 32'(q_b.pop_front()));
        end
        if (rst) begin
            seen_frame = 1'b0;
            low_run    = 0;
        end else if (vout_a) begin
            if (!prev_vout && seen_frame) check("ifg_spacing", 32'(low_run >= IFG + 2), 1);
            seen_frame = 1'b1;
            low_run    = 0;
        end else begin
            low_run++;
        end
        prev_vout = vout_a;
    end

    task automatic wait_gnt_a(input int budget, output int cyc);
        cyc = budget + 1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (gnt_a != 4'b0000) begin
                cyc = c;
                break;
            end
        end
        check("gnt_wait_a", 32'(gnt_a != 4'b0000), 1);
    endtask

    // Streams one frame on instance A starting at a negedge with grant seen
    task automatic send_a(input int src, input int len, input logic [7:0] base,
                          input bit incr, input bit drop_req);
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            b = incr ? base + 8'(i) : base;
            if (i == 1) begin
                check("first_byte_vout", 32'(vout_a), 1);
                check("first_byte_dout", 32'(dout_a), 32'(base));
            end
            din_a[8*src +: 8] = b;
            vin_a[src] = 1'b1;
            q_a.push_back(b);
            if (drop_req && i == 0) req_a[src] = 1'b0;
            @(negedge clk);
        end
        vin_a[src] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int src, cyc;
        rst = 1'b1; rst_b = 1'b1;
        req_a = '0; vin_a = '0; din_a = '0; noise_en = 1'b0;
        req_b = '0; vin_b = '0; din_b = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt",     32'(gnt_a), 0);
        check("rst_dout",    32'(dout_a), 0);
        check("rst_vout",    32'(vout_a), 0);
        check("rst_busy",    32'(busy_a), 0);
        check("rst_to_err",  32'(to_err_a), 0);
        check("rst_len_err", 32'(len_err_a), 0);
        check("rst_gnt_b",   32'(gnt_b), 0);
        check("rst_vout_b",  32'(vout_b), 0);
        rst = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // All four request: expect order 0,1,2,3,0 with minimum spacing
        req_a = 4'hF;
        for (int k = 0; k < 5; k++) begin
            src = k % 4;
            wait_gnt_a(100, cyc);
            check("rr_gnt", 32'(gnt_a), 32'(1) << src);
            if (k > 0) check("rr_spacing", 32'(cyc), IFG + 2);
            send_a(src, 10, 8'(src), 1'b0, k != 0);
        end

        // Single source, 60 incrementing bytes, then re-request for gap timing
        req_a = 4'b0100;
        wait_gnt_a(100, cyc);
        check("ss_gnt", 32'(gnt_a), 4);
        send_a(2, 60, 8'h00, 1'b1, 1'b1);
        req_a[2] = 1'b1;
        wait_gnt_a(100, cyc);
        check("ss_regrant_gap", 32'(cyc), IFG + 2);
        check("ss_regrant_src", 32'(gnt_a), 4);
        check("ss_queue_empty", 32'(q_a.size()), 0);
        req_a = '0;
        @(negedge clk);
        check("abandon_gnt",    32'(gnt_a), 0);
        check("abandon_busy",   32'(busy_a), 0);
        check("abandon_to_err", 32'(to_err_a), 0);

        // Grant timeout on source 1, source 2 waiting behind it
        req_a = 4'b0110;
        wait_gnt_a(10, cyc);
        check("to_gnt_src", 32'(gnt_a), 2);
        cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (to_err_a) begin
                cyc = c;
                break;
            end
        end
        check("to_latency",  32'(cyc), GT);
        check("to_gnt_drop", 32'(gnt_a), 0);
        check("to_vout",     32'(vout_a), 0);
        check("to_dout",     32'(dout_a), 0);
        check("to_busy",     32'(busy_a), 1);
        req_a[1] = 1'b0;
        wait_gnt_a(100, cyc);
        check("to_next_gap", 32'(cyc), IFG + 1);
        check("to_next_src", 32'(gnt_a), 4);
        req_a = '0;
        @(negedge clk);
        check("to_idle_busy", 32'(busy_a), 0);

        // Noise on vin[3] while source 0 owns the path
        din_a[31:24] = 8'hEE;
        noise_en = 1'b1;
        req_a = 4'b0001;
        wait_gnt_a(10, cyc);
        check("noise_gnt", 32'(gnt_a), 1);
        send_a(0, 8, 8'hA0, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        check("noise_q_empty", 32'(q_a.size()), 0);
        noise_en = 1'b0;

        // Reset in the middle of a frame, at its fifth byte
        req_a = 4'b0010;
        wait_gnt_a(10, cyc);
        check("mid_rst_gnt", 32'(gnt_a), 2);
        for (int i = 0; i < 4; i++) begin
            din_a[15:8] = 8'h50 + 8'(i);
            vin_a[1] = 1'b1;
            q_a.push_back(8'h50 + 8'(i));
            @(negedge clk);
        end
        din_a[15:8] = 8'h54;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_vout", 32'(vout_a), 0);
        check("mid_rst_gnt0", 32'(gnt_a), 0);
        check("mid_rst_busy", 32'(busy_a), 0);
        check("mid_rst_q",    32'(q_a.size()), 0);
        vin_a = '0;
        req_a = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        wait_gnt_a(10, cyc);
        check("mid_rst_restart_src", 32'(gnt_a), 1);
        check("mid_rst_restart_lat", 32'(cyc), 1);
        req_a = '0;
        @(negedge clk);
        check("mid_rst_release", 32'(gnt_a), 0);

        // Truncation on instance B: 20 bytes offered, 16 forwarded
        req_b = 4'b0001;
        cyc = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (gnt_b != 4'b0000) begin
                cyc = c;
                break;
            end
        end
        check("tr_gnt", 32'(gnt_b), 1);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                check("tr_len_err",  32'(len_err_b), 32'(i == 17));
                check("tr_gnt_held", 32'(gnt_b), 1);
            end
            din_b[7:0] = 8'h10 + 8'(i);
            vin_b[0] = 1'b1;
            if (i < 16) q_b.push_back(8'h10 + 8'(i));
            if (i == 0) req_b[0] = 1'b0;
            @(negedge clk);
        end
        check("tr_len_err_end",  32'(len_err_b), 0);
        check("tr_gnt_held_end", 32'(gnt_b), 1);
        vin_b = '0;
        req_b[0] = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (gnt_b != 4'b0000) begin
                cyc = c;
                break;
            end
        end
        check("tr_gap",        32'(cyc), IFG + 2);
        check("tr_vout_count", 32'(n_vout_b), 16);
        check("tr_q_empty",    32'(q_b.size()), 0);
        req_b = '0;
        @(negedge clk);

        check("count_to_err_a",  32'(n_to_err_a), 1);
        check("count_len_err_a", 32'(n_len_err_a), 0);
        check("count_to_err_b",  32'(n_to_err_b), 0);
        check("count_len_err_b", 32'(n_len_err_b), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_tx_arbiter.md
Name: stream_tx_arbiter

Overview:
- Round-robin arbiter that shares one byte-stream transmit path (`dout`/`vout`, one byte per clock while valid) between N requesters.
- Each requester raises `req`, waits for its `gnt` bit, then streams one frame as contiguous `vin` cycles. End of frame is `vin` falling.
- The arbiter enforces a minimum inter-frame gap, a grant-to-data timeout and a maximum frame length.
- Sits between the per-protocol frame generators and the MAC transmit input.

Parameters:
- N, 4, number of requesters (2..16).
- IFG, 12, idle cycles forced on `vout` after every frame, truncation or timeout (>=1).
- GRANT_TIMEOUT, 64, cycles allowed between `gnt` assertion and first `vin` of the granted source (>=1).
- MAX_LEN, 1518, maximum bytes forwarded per frame (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req  in  N  per-source transmit request, level.
- din  in  8*N  per-source byte; source i occupies bits [8i+7:8i].
- vin  in  N  per-source byte valid.
- gnt  out  N  one-hot grant, registered.
- dout  out  8  arbitrated byte, registered.
- vout  out  1  arbitrated valid, registered.
- busy  out  1  high in every state except IDLE.
- to_err  out  1  one-cycle pulse on grant timeout.
- len_err  out  1  one-cycle pulse on MAX_LEN truncation.

Behaviour:
- Reset: all outputs 0. State IDLE. RR pointer = 0. Counters = 0. Rst mid-frame aborts immediately; `vout` is 0 the cycle after rst is sampled.
- Latency: `dout`/`vout` are `din[sel]`/`vin[sel]` delayed by exactly 1 clk while in ACTIVE.
- Non-granted `vin`/`din` are ignored in all states.
- IDLE:
  - If any req is set, select the first set bit at or after `ptr`, wrapping modulo N.
  - Register `sel`, set `gnt[sel]` next cycle, go to GRANT, clear the timeout counter.
  - Set `ptr = sel+1` mod N at selection.
- GRANT:
  - `vin[sel]`=1 -> ACTIVE; that byte is forwarded and byte count = 1.
  - Else if `req[sel]`=0 -> drop `gnt`, go to IDLE, no error, no gap.
  - Else increment the counter. On reaching GRANT_TIMEOUT -> drop `gnt`, pulse `to_err`, go to GAP.
- ACTIVE:
  - Each `vin[sel]`=1 cycle forwards the byte and increments the byte count.
  - `vin[sel]`=0 -> `vout`=0 next cycle, drop `gnt`, go to GAP.
  - If `vin[sel]`=1 while count==MAX_LEN, the byte is not forwarded: `vout`=0, pulse `len_err`, go to DRAIN.
- DRAIN: `gnt` is held and nothing is forwarded. When `vin[sel]`=0 -> drop `gnt`, go to GAP.
- GAP:
  - `vout`=0 for exactly IFG cycles, counted from the first cycle `vout` is low after the frame, then go to IDLE.
  - Requests made during GAP are sampled only in IDLE.
  - Minimum spacing between frames on `vout` = IFG idle cycles + 1 arbitration cycle + 1 grant cycle.
- Widths:
  - Byte counter is clog2(MAX_LEN+1) bits.
  - Timeout and gap counters are sized to their parameters.
  - No counter wraps; each saturates at its terminal value.
- Simultaneous requests resolve by RR only; no priority. A source holding `req` continuously gets every N-th slot under full load.
- `gnt` is never asserted for more than one source. `gnt` and `vout` are never both high for a non-selected source.

Test Plan:
- Single source: `req[2]`=1, `gnt[2]` seen, 60-byte frame 0x00..0x3B on `vin[2]` -> `vout` high 60 cycles, bytes identical, 1-cycle delayed. Then 12 idle cycles before any new `gnt`. No errors.
- All 4 `req` high, each sends 10 bytes (value = source id) -> frames appear in order 0,1,2,3,0. Each frame is separated by >=12 `vout`-low cycles. `gnt` is one-hot throughout.
- Timeout: `req[1]`=1, `vin` never set -> `to_err` pulses 64 cycles after `gnt[1]`. `gnt` drops and `dout`/`vout` stay 0. Next grant goes to source 2 if it is requesting.
- Truncation, MAX_LEN=16: source sends 20 bytes -> exactly 16 bytes on `vout`. `len_err` pulses on byte 17. `gnt` stays high until `vin` falls after byte 20, then the 12-cycle gap follows.
- Rst asserted at byte 5 of a frame -> next cycle `vout`=0, `gnt`=0, `busy`=0. After release the arbiter restarts at source 0.
- Noise: `vin[3]` toggling while source 0 is granted -> never appears on `vout`.
